avr_serial_tx: RTL
==================

Name: avr_serial_tx

Overview:
UART transmitter driving the FPGA-to-AVR serial line; the send-side counterpart of the cclk-based AVR readiness detection.
Serialises one byte per handshake as 8N1, LSB first.
Holds the line idle until the AVR is reported ready and honours the AVR's receive-busy flow-control pin.
Sits between user logic and the top-level avr_rx pin, fed by the ready output of the cclk detector.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 500000, line rate in bits/s
CLK_PER_BIT, CLK_FREQ/BAUD (100), clocks per bit; derived localparam; bit counter width $clog2(CLK_PER_BIT)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
avr_ready  input  1  AVR configured and running; level from cclk detector
block  input  1  AVR receive buffer full (avr_rx_busy pin); asynchronous to clk
data  input  8  byte to send; sampled on accept
new_data  input  1  send request; accepted only in a cycle where busy=0
busy  output  1  1 = cannot accept new_data this cycle
tx  output  1  serial line; idle high

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, tx=1, busy=1, counters=0, block_sync=11.
  - Any frame in flight is dropped immediately.
- block: 2-flop synchroniser; block_s is the second stage. Latency 2 clocks.
- busy (registered): 1 when any of the following holds, else 0:
  - state!=IDLE
  - block_s=1
  - avr_ready=0
  - new_data accepted this cycle
- Accept: state=IDLE, busy=0 and new_data=1 → latch data into shift register; next state START.
- new_data while busy=1 is ignored; no queuing.
- FSM:
  - IDLE: tx=1.
  - START: tx=0 for CLK_PER_BIT clocks → DATA, bit_idx=0.
  - DATA: tx=shift[bit_idx] for CLK_PER_BIT clocks each. bit_idx 0..7; after bit 7 → STOP.
  - STOP: tx=1 for CLK_PER_BIT clocks → IDLE.
- tx is registered. The first start-bit clock appears one cycle after the accept edge.
- Frame length is exactly 10*CLK_PER_BIT clocks of tx activity. busy falls on the clock after STOP ends, provided block_s=0 and avr_ready=1.
- block_s or avr_ready changing mid-frame does not abort or stretch the frame; they only gate the next accept.
- Back-to-back: if new_data is held high and gating allows, the next start bit follows the stop bit after exactly one IDLE clock.
- Bit counter wraps to 0 at CLK_PER_BIT-1; no drift across bits.

Optional Feature:
Macro AVR_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA bit 7 and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLK_PER_BIT clocks.
  - Frame length is 11*CLK_PER_BIT clocks.
- Undefined: no PARITY state, no parity logic; 8N1, 10-bit frame.

Decomposition:
- Shared package avr_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - FRAME_BITS constant
  - default CLK_FREQ and BAUD constants, shared with the serial receiver and cclk detector
- Natural sub-module: sync2 (2-flop synchroniser), used for block and reusable for other AVR pins.
- The FSM and counters stay in avr_serial_tx.

Test Plan:
All scenarios use CLK_PER_BIT=4.
1. Reset: hold rst=0 for 3 clocks with new_data=1 → tx=1 and busy=1 throughout. After release with avr_ready=1 and block=0 → busy=0 by the 3rd clock.
2. Send 0xA5: pulse new_data for one clock → tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. busy=1 for the whole frame, then 0.
3. avr_ready=0: assert new_data for 20 clocks → tx stays 1 and busy stays 1. Raise avr_ready → busy=0 next clock; the byte is sent only on a fresh new_data.
4. Flow control: raise block mid-frame → frame completes unchanged and busy stays 1 after the stop bit. Drop block → busy=0 exactly 3 clocks later.
5. Back-to-back: new_data held high with 0x00 then 0xFF → two 40-clock frames separated by exactly one idle clock. With AVR_TX_PARITY_EN: 44-clock frames, parity bits 0 and 0.
6. Mid-frame reset: rst=0 during DATA bit 3 → tx=1 on the next clock. After release the line stays idle until a new request arrives.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared definitions for the FPGA-to-AVR link: state encoding, frame size and default clocking.
// Frame size depends on AVR_TX_PARITY_EN (even parity bit inserted before the stop bit).
package avr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 500_000;

`ifdef AVR_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for single-bit AVR pins; q lags d by two clocks.
// RESET_VAL lets a pin start in its "safe" level (e.g. busy asserted).
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/avr_serial_tx.sv
// UART transmitter towards the AVR: 8N1 LSB first, gated by avr_ready and the AVR busy pin.
// Define AVR_TX_PARITY_EN to append an even parity bit (8E1, 11-bit frame).
module avr_serial_tx
    import avr_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       avr_ready,
    input  logic       block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       busy,
    output logic       tx
);

    localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n;
    logic             block_s;
    logic             bit_done;

    // block starts high so nothing is sent until the AVR pin has really been sampled.
    sync2 #(.RESET_VAL(1'b1)) u_block_sync (
        .clk (clk),
        .rst (rst),
        .d   (block),
        .q   (block_s)
    );

    assign bit_done = (cnt == CNT_LAST);

    // tx_n is derived from the current state, so the line lags the FSM by one clock.
    always_comb begin
        state_n   = state;
        cnt_n     = bit_done ? '0 : cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (new_data && !busy) begin
                    shift_n = data;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_done) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                end
            end
            DATA: begin
                tx_n = shift[bit_idx];
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef AVR_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef AVR_TX_PARITY_EN
            PARITY: begin
                tx_n = ^shift;
                if (bit_done) state_n = STOP;
            end
`endif
            STOP: begin
                tx_n = 1'b1;
                if (bit_done) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // busy looks at the next state so a finished frame frees the line after one idle clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= (state_n != IDLE) || block_s || !avr_ready;
        end
    end

endmodule
